// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the core MEM stage and a debug master.
// Grants are combinational; read data is routed back to the owner one cycle later.
module dmem_arbiter #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int LOCK_MAX   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic [2:0]        core_funct3,
  output logic              core_stall,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic              dbg_lock,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_funct3,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int LW = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_DBG} owner_e;

  owner_e            rd_owner, rd_owner_nxt;
  logic [SW-1:0]     starve_cnt, starve_nxt;
  logic [LW-1:0]     lock_cnt, lock_cnt_nxt;
  logic              lock_own, lock_own_nxt;
  logic              lock_spent, dbg_prio, core_win, dbg_win;
  logic [DATA_W-1:0] core_rdata_q, dbg_rdata_q;

  // Grant and memory-port drive. Raw wins follow inputs even in reset; only
  // the strobes and handshakes are masked so nothing reaches memory.
  always_comb begin
    lock_spent = (lock_cnt == LW'(LOCK_MAX));
    dbg_prio   = (starve_cnt == SW'(STARVE_MAX)) || (lock_own && !lock_spent);
    core_win   = core_req && !(dbg_req && dbg_prio);
    dbg_win    = dbg_req && !core_win;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_funct3 = 3'b000;
    if (core_win) begin
      mem_rd     = !core_we && !reset;
      mem_wr     = core_we && !reset;
      mem_addr   = core_addr;
      mem_wdata  = core_wdata;
      mem_funct3 = core_funct3;
    end else if (dbg_win) begin
      mem_rd     = !dbg_we && !reset;
      mem_wr     = dbg_we && !reset;
      mem_addr   = dbg_addr;
      mem_wdata  = dbg_wdata;
      mem_funct3 = 3'b010;
    end

    core_stall = core_req && !core_win && !reset;
    dbg_gnt    = dbg_win && !reset;
  end

  // Fairness counters and read-return owner.
  always_comb begin
    starve_nxt   = '0;
    lock_own_nxt = lock_own;
    lock_cnt_nxt = lock_cnt;
    rd_owner_nxt = OWN_NONE;

    if (dbg_req && !dbg_win)
      starve_nxt = (starve_cnt == SW'(STARVE_MAX)) ? starve_cnt : starve_cnt + SW'(1);

    if (!dbg_req || !dbg_lock) begin
      lock_own_nxt = 1'b0;
      lock_cnt_nxt = '0;
    end else if (dbg_win) begin
      lock_own_nxt = 1'b1;
      lock_cnt_nxt = lock_spent ? lock_cnt : lock_cnt + LW'(1);
    end else if (core_win) begin
      // The forced core slot keeps ownership so the burst resumes right after it.
      lock_own_nxt = lock_spent;
      lock_cnt_nxt = '0;
    end

    if (core_win && !core_we)
      rd_owner_nxt = OWN_CORE;
    else if (dbg_win && !dbg_we)
      rd_owner_nxt = OWN_DBG;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      rd_owner     <= OWN_NONE;
      starve_cnt   <= '0;
      lock_cnt     <= '0;
      lock_own     <= 1'b0;
      // NOTE: the held read data is reset so a returned word never leaks across reset.
      core_rdata_q <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      rd_owner   <= rd_owner_nxt;
      starve_cnt <= starve_nxt;
      lock_cnt   <= lock_cnt_nxt;
      lock_own   <= lock_own_nxt;
      if (rd_owner == OWN_CORE) core_rdata_q <= mem_rdata;
      if (rd_owner == OWN_DBG)  dbg_rdata_q  <= mem_rdata;
    end
  end

  assign core_rvalid = (rd_owner == OWN_CORE);
  assign dbg_rvalid  = (rd_owner == OWN_DBG);
  assign core_rdata  = core_rvalid ? mem_rdata : core_rdata_q;
  assign dbg_rdata   = dbg_rvalid ? mem_rdata : dbg_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed scenarios plus randomized traffic,
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_dmem_arbiter;

  localparam int ADDR_W     = 9;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;
  localparam int LOCK_MAX   = 8;

  typedef struct packed {
    logic              rst;
    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic [2:0]        core_funct3;
    logic              dbg_req;
    logic              dbg_we;
    logic              dbg_lock;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
  } stim_t;

  typedef struct {
    bit          is_dbg;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              core_req, core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic [2:0]        core_funct3;
  logic              core_stall, core_rvalid;
  logic [DATA_W-1:0] core_rdata;
  logic              dbg_req, dbg_we, dbg_lock;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt, dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;
  logic              mem_rd, mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [2:0]        mem_funct3;
  logic [DATA_W-1:0] mem_rdata;

  dmem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX), .LOCK_MAX(LOCK_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_funct3(core_funct3),
    .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   dbg_rv_count = 0;
  exp_t sb_q[$];

  // Reference-model state: plain counters following the arbitration rules.
  int          m_starve = 0;
  int          m_lock_cnt = 0;
  bit          m_lock_own = 0;
  bit          pend_valid = 0;
  logic [31:0] pend_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One bus cycle: drive inputs after the falling edge, check the combinational
  // response, queue any expected read return, then advance the model.
  task automatic step(input stim_t s, input logic [31:0] rdat,
                      output logic g_core, output logic g_dbg);
    bit          prio, mc, md;
    logic [31:0] e_addr, e_wdata, e_f3;
    @(negedge clk);
    cyc++;
    reset       = s.rst;
    core_req    = s.core_req;
    core_we     = s.core_we;
    core_addr   = s.core_addr;
    core_wdata  = s.core_wdata;
    core_funct3 = s.core_funct3;
    dbg_req     = s.dbg_req;
    dbg_we      = s.dbg_we;
    dbg_lock    = s.dbg_lock;
    dbg_addr    = s.dbg_addr;
    dbg_wdata   = s.dbg_wdata;
    mem_rdata   = pend_valid ? pend_data : $urandom();
    pend_valid  = 0;
    #1;
    prio = (m_starve >= STARVE_MAX) || (m_lock_own && m_lock_cnt < LOCK_MAX);
    mc   = s.core_req && !(s.dbg_req && prio);
    md   = s.dbg_req && !mc;
    if (s.rst) begin
      check("rst_core_stall", 32'(core_stall), 32'(0));
      check("rst_dbg_gnt",    32'(dbg_gnt),    32'(0));
      check("rst_mem_rd",     32'(mem_rd),     32'(0));
      check("rst_mem_wr",     32'(mem_wr),     32'(0));
    end else begin
      e_addr  = mc ? 32'(s.core_addr)   : md ? 32'(s.dbg_addr)  : 32'(0);
      e_wdata = mc ? 32'(s.core_wdata)  : md ? 32'(s.dbg_wdata) : 32'(0);
      e_f3    = mc ? 32'(s.core_funct3) : md ? 32'(3'b010)      : 32'(0);
      check("core_stall", 32'(core_stall), 32'(s.core_req && !mc));
      check("dbg_gnt",    32'(dbg_gnt),    32'(md));
      check("mem_rd",     32'(mem_rd),     32'((mc && !s.core_we) || (md && !s.dbg_we)));
      check("mem_wr",     32'(mem_wr),     32'((mc && s.core_we) || (md && s.dbg_we)));
      check("mem_addr",   32'(mem_addr),   e_addr);
      check("mem_wdata",  32'(mem_wdata),  e_wdata);
      check("mem_funct3", 32'(mem_funct3), e_f3);
      if ((mc && !s.core_we) || (md && !s.dbg_we)) begin
        sb_q.push_back('{is_dbg: md, data: rdat, due: cyc + 1});
        pend_valid = 1;
        pend_data  = rdat;
      end
    end
    g_core = core_req && !core_stall && !reset;
    g_dbg  = dbg_gnt;

    if (s.rst) begin
      m_starve = 0; m_lock_own = 0; m_lock_cnt = 0;
    end else begin
      if (s.dbg_req && !md) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : m_starve;
      else                  m_starve = 0;
      if (!s.dbg_req || !s.dbg_lock) begin
        m_lock_own = 0; m_lock_cnt = 0;
      end else if (md) begin
        m_lock_own = 1;
        if (m_lock_cnt < LOCK_MAX) m_lock_cnt++;
      end else if (mc) begin
        if (m_lock_cnt != LOCK_MAX) m_lock_own = 0;
        m_lock_cnt = 0;
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever a return is due and checks owner/data,
  // and that rdata holds its last value while rvalid is low.
  initial begin : monitor
    exp_t        e;
    bit          exp_c, exp_d, prev_rst;
    logic [31:0] last_c, last_d;
    prev_rst = 0; last_c = '0; last_d = '0;
    forever begin
      @(negedge clk);
      #2;
      exp_c = 0; exp_d = 0;
      if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
        e = sb_q.pop_front();
        exp_c = !e.is_dbg;
        exp_d = e.is_dbg;
      end
      if (prev_rst) begin last_c = '0; last_d = '0; end
      if (cyc >= 2) begin
        check("core_rvalid", 32'(core_rvalid), 32'(exp_c));
        check("dbg_rvalid",  32'(dbg_rvalid),  32'(exp_d));
        if (exp_c) last_c = e.data;
        if (exp_d) last_d = e.data;
        check("core_rdata", core_rdata, last_c);
        check("dbg_rdata",  dbg_rdata,  last_d);
      end
      if (dbg_rvalid === 1'b1) dbg_rv_count++;
      prev_rst = (reset === 1'b1);
    end
  end

  initial begin : driver
    stim_t s;
    logic  gc, gd;
    bit    dbg_hold;
    int    grants, rv_before;

    // Reset state and core-only load.
    s = '0; s.rst = 1;
    step(s, '0, gc, gd);
    step(s, '0, gc, gd);
    s = '0; s.core_req = 1; s.core_addr = 9'h010; s.core_funct3 = 3'b010;
    step(s, 32'hDEADBEEF, gc, gd);
    check("load_grant", 32'(gc), 32'(1));
    s = '0;
    step(s, '0, gc, gd);
    check("load_rdata", core_rdata, 32'hDEADBEEF);

    // Starvation: debug forced in after STARVE_MAX denied cycles.
    s = '0; s.rst = 1;
    step(s, '0, gc, gd);
    for (int i = 0; i < 6; i++) begin
      s = '0; s.core_req = 1; s.core_addr = 9'(i * 4);
      s.dbg_req = (i <= 4); s.dbg_addr = 9'h100;
      step(s, $urandom(), gc, gd);
      check("starve_dbg_gnt", 32'(gd), 32'(i == 4));
      check("starve_core_gnt", 32'(gc), 32'(i != 4));
    end

    // Locked debug burst of 12 reads against a constantly requesting core.
    s = '0; s.rst = 1;
    step(s, '0, gc, gd);
    grants = 0;
    rv_before = dbg_rv_count;
    for (int i = 0; i < 17; i++) begin
      s = '0; s.core_req = 1; s.core_addr = 9'h040;
      s.dbg_req = (grants < 12); s.dbg_lock = 1; s.dbg_addr = 9'(grants * 4);
      step(s, $urandom(), gc, gd);
      check("lock_dbg_gnt", 32'(gd), 32'((i >= 4 && i <= 11) || (i >= 13 && i <= 16)));
      if (gd) grants++;
    end
    s = '0;
    step(s, '0, gc, gd);
    step(s, '0, gc, gd);
    check("lock_grants", 32'(grants), 32'(12));
    check("lock_rvalid_count", 32'(dbg_rv_count - rv_before), 32'(12));

    // Alternating core and debug reads.
    for (int i = 0; i < 6; i++) begin
      s = '0;
      if (i % 2 == 0) begin s.core_req = 1; s.core_addr = 9'h080; end
      else begin s.dbg_req = 1; s.dbg_addr = 9'h084; end
      step(s, (i % 2 == 0) ? 32'hAAAA0000 : 32'h5555FFFF, gc, gd);
    end

    // Reset in the same cycle as a debug read, then immediate core access.
    s = '0; s.rst = 1; s.dbg_req = 1; s.dbg_addr = 9'h0C0;
    step(s, 32'hBAD0BAD0, gc, gd);
    s = '0; s.core_req = 1; s.core_addr = 9'h0C4; s.core_funct3 = 3'b100;
    step(s, 32'hC0FFEE00, gc, gd);
    check("post_reset_core_gnt", 32'(gc), 32'(1));

    // Debug word write with the core idle.
    s = '0; s.dbg_req = 1; s.dbg_we = 1; s.dbg_addr = 9'h020; s.dbg_wdata = 32'h12345678;
    step(s, '0, gc, gd);
    check("dbg_write_gnt", 32'(gd), 32'(1));

    // Randomized traffic; debug keeps its request stable until granted.
    dbg_hold = 0;
    s = '0;
    for (int i = 0; i < 1500; i++) begin
      s.rst         = ($urandom_range(0, 99) == 0);
      s.core_req    = ($urandom_range(0, 9) < 6);
      s.core_we     = 1'($urandom_range(0, 1));
      s.core_addr   = ADDR_W'($urandom());
      s.core_wdata  = $urandom();
      s.core_funct3 = 3'($urandom());
      if (!dbg_hold) begin
        s.dbg_req   = 1'($urandom_range(0, 1));
        s.dbg_we    = ($urandom_range(0, 3) == 0);
        s.dbg_lock  = ($urandom_range(0, 2) != 0);
        s.dbg_addr  = ADDR_W'($urandom());
        s.dbg_wdata = $urandom();
      end
      step(s, $urandom(), gc, gd);
      dbg_hold = s.dbg_req && !gd;
    end

    s = '0;
    step(s, '0, gc, gd);
    step(s, '0, gc, gd);
    check("scoreboard_drained", 32'(sb_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 9: data-memory byte address width.
REQ-002 Parameter DATA_W, default 32: data width.
REQ-003 Parameter STARVE_MAX, default 4: consecutive denied debug cycles before debug is forced to win.
REQ-004 Parameter LOCK_MAX, default 8: maximum consecutive debug grants under lock before one core slot is forced.
REQ-005 Clock clk; reset reset, synchronous, active-high.
REQ-006 core_req  in  1  MEM-stage access request; core_we in 1; core_addr in ADDR_W; core_wdata in DATA_W; core_funct3 in 3 (access size).
REQ-007 core_stall  out  1  core request pending and not granted this cycle; core_rvalid out 1; core_rdata out DATA_W.
REQ-008 dbg_req  in  1; dbg_we in 1; dbg_lock in 1 (burst hold); dbg_addr in ADDR_W; dbg_wdata in DATA_W; debug accesses are always word (funct3=3'b010).
REQ-009 dbg_gnt  out  1  debug access issued this cycle; dbg_rvalid out 1; dbg_rdata out DATA_W.
REQ-010 mem_rd, mem_wr  out  1 each; mem_addr out ADDR_W; mem_wdata out DATA_W; mem_funct3 out 3; mem_rdata in DATA_W (valid the cycle after mem_rd).

Function
REQ-011 Grant decided combinationally each cycle; at most one of core, debug granted; the granted request drives mem_* the same cycle; with no grant, mem_rd = mem_wr = 0, mem_addr/mem_wdata/mem_funct3 = 0.
REQ-012 Default priority: core over debug.
REQ-013 starve_cnt (saturating at STARVE_MAX): +1 each cycle dbg_req=1 and not granted; cleared on dbg grant or dbg_req=0.
REQ-014 Debug wins over a simultaneous core request when starve_cnt == STARVE_MAX, or when lock_own=1 and lock_cnt < LOCK_MAX.
REQ-015 lock_own set on a dbg grant with dbg_lock=1; cleared when dbg_req=0 or dbg_lock=0, or on a core grant.
REQ-016 lock_cnt: +1 per consecutive locked dbg grant, cleared when lock_own clears; at LOCK_MAX the core wins the next cycle if core_req=1, after which lock_cnt=0 and lock arbitration resumes.
REQ-017 core_stall = core_req & ~core granted; dbg_gnt = dbg granted; debug holds its request stable until dbg_gnt.
REQ-018 Read-return register rd_owner {NONE, CORE, DBG} captures the owner of a granted read; next cycle, exactly that requester's rvalid pulses 1 cycle, with its rdata = mem_rdata.
REQ-019 Writes produce no rvalid; rdata outputs hold their last value when rvalid=0.
REQ-020 Back-to-back reads by alternating owners return in issue order, one per cycle, no bubble.
REQ-021 Simultaneous core read in cycle N and debug grant in N+1: core_rvalid in N+1, dbg_rvalid in N+2.
REQ-022 core_funct3 is passed unchanged on a core grant; no alignment checking is done in this block.

Reset
REQ-023 reset clears starve_cnt, lock_cnt, lock_own, and sets rd_owner=NONE; core_rvalid, dbg_rvalid, core_rdata, dbg_rdata = 0 at the first edge.
REQ-024 A read granted in the cycle reset is asserted produces no rvalid afterwards.
REQ-025 Combinational grant outputs follow inputs during reset, but reset forces core_stall = 0, dbg_gnt = 0 and mem_rd = mem_wr = 0.

Verification
REQ-026 Core-only load at addr 0x010, mem_rdata=0xDEADBEEF -> mem_rd in cycle N, core_stall=0, core_rvalid=1 and core_rdata=0xDEADBEEF in N+1.
REQ-027 core_req and dbg_req both held, STARVE_MAX=4 -> core granted in cycles 0-3, dbg_gnt=1 and core_stall=1 in cycle 4, starve_cnt=0 in cycle 5.
REQ-028 dbg_lock=1 burst of 12 reads with core_req held, LOCK_MAX=8 -> dbg granted in cycles 4-11, core in cycle 12, debug resumes in cycle 13; dbg_rvalid count = grants.
REQ-029 Alternating core read (0xAAAA0000) and debug read (0x5555FFFF) -> core_rvalid and dbg_rvalid alternate, one cycle after each grant, data matched to owner.
REQ-030 reset asserted in the same cycle as a debug read grant -> no dbg_rvalid next cycle, all counters 0, core-only access succeeds in the first cycle after reset.
REQ-031 Debug write 0x12345678 to addr 0x020 with no core_req -> mem_wr=1, mem_funct3=3'b010, dbg_gnt=1, no rvalid on either port.
